// File: rtl/servo_pkg.sv
// Shared helpers for the servo PWM bank: derived widths and parameter legality.
package servo_pkg;

    // Channel-select width; a single-channel bank still needs a 1-bit select.
    function automatic int ch_width(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    // Comparator width: one bit wider than the frame counter so that
    // MIN_TICKS + position can never wrap during the compare.
    function automatic int cmp_width(input int frame_ticks);
        return $clog2(frame_ticks) + 1;
    endfunction

    // True when the parameter set produces a well-formed pulse in every frame.
    function automatic bit params_ok(input int nch, input int pos_w, input int div,
                                     input int frame_ticks, input int min_ticks,
                                     input int reset_pos, input int slew_step);
        return (nch >= 1) && (pos_w >= 1) && (pos_w < 31) && (div >= 2) &&
               (frame_ticks >= 2) && (min_ticks >= 0) &&
               (min_ticks + (1 << pos_w) - 1 < frame_ticks) &&
               (reset_pos >= 0) && (reset_pos < (1 << pos_w)) &&
               (slew_step >= 1);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: pending/active position double buffer, enable latch,
// optional per-frame slew limiter (SERVO_SLEW_EN) and the pulse comparator.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int POS_W       = 8,
    parameter int FRAME_TICKS = 2048,
    parameter int MIN_TICKS   = 46,
    parameter int RESET_POS   = 128
`ifdef SERVO_SLEW_EN
    ,
    parameter int SLEW_STEP   = 4
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [POS_W-1:0]                 wr_pos,
    input  logic                             en_req,
    input  logic                             boundary,
    input  logic [$clog2(FRAME_TICKS)-1:0]   fc,
    output logic                             servo
);

    localparam int                CW    = cmp_width(FRAME_TICKS);
    localparam logic [CW-1:0]     MIN_C = CW'(MIN_TICKS);
    localparam logic [POS_W-1:0]  RST_C = POS_W'(RESET_POS);

    logic [POS_W-1:0] pending;
    logic [POS_W-1:0] active;
    logic [POS_W-1:0] next_pos;
    logic             en_act;
    logic [CW-1:0]    threshold;

`ifdef SERVO_SLEW_EN
    localparam logic [POS_W-1:0] STEP_C = POS_W'(SLEW_STEP);
    logic [POS_W-1:0] diff;

    // Move active toward pending by at most SLEW_STEP, landing exactly on pending.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_pos = pending;
        diff     = '0;
        if (pending > active) begin
            diff = pending - active;
            if (int'(diff) > SLEW_STEP) next_pos = active + STEP_C;
        end else if (active > pending) begin
            diff = active - pending;
            if (int'(diff) > SLEW_STEP) next_pos = active - STEP_C;
        end
    end
`else
    assign next_pos = pending;
`endif

    assign threshold = MIN_C + CW'(active);

    // Double buffer: writes land in pending; active and enable change only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are a handful of flops, not a RAM, so they carry an async reset like any other state.
        if (!rst_n) begin
            pending <= RST_C;
            active  <= RST_C;
            en_act  <= 1'b0;
        end else begin
            // NOTE: non-blocking, so a boundary-cycle write leaves active loading the pre-write pending.
            if (wr_en) pending <= wr_pos;
            if (boundary) begin
                active <= next_pos;
                en_act <= en_req;
            end
        end
    end

    // Registered pulse: high while the frame counter is below MIN_TICKS + active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) servo <= 1'b0;
        else        servo <= en_act && ({1'b0, fc} < threshold);
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM bank: shared prescaler and frame counter,
// write decode and frame_sync; per-channel logic lives in servo_pwm_channel.
// Optional feature macro: SERVO_SLEW_EN (per-frame slew limit of SLEW_STEP).
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int POS_W       = 8,
    parameter int DIV         = 94,
    parameter int FRAME_TICKS = 2048,
    parameter int MIN_TICKS   = 46,
    parameter int RESET_POS   = 128,
    parameter int SLEW_STEP   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ch_width(NCH)-1:0] wr_ch,
    input  logic [POS_W-1:0]        wr_pos,
    input  logic [NCH-1:0]          ch_en,
    output logic [NCH-1:0]          servo,
    output logic                    frame_sync
);

    localparam int CHW = ch_width(NCH);
    localparam int FCW = $clog2(FRAME_TICKS);
    localparam int PSW = $clog2(DIV);

    if (!params_ok(NCH, POS_W, DIV, FRAME_TICKS, MIN_TICKS, RESET_POS, SLEW_STEP)) begin : g_bad_params
        $error("servo_pwm_bank: illegal parameter set");
    end

    logic [PSW-1:0] presc;
    logic [FCW-1:0] fc;
    logic           tick;
    logic           boundary;

    assign tick     = (presc == PSW'(DIV - 1));
    assign boundary = tick && (fc == FCW'(FRAME_TICKS - 1));

    // Prescaler 0..DIV-1 and frame counter 0..FRAME_TICKS-1 advancing on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            fc    <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (boundary)  fc <= '0;
            else if (tick) fc <= fc + 1'b1;
        end
    end

    // One-clock frame_sync marking the frame the boundary just opened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_sync <= 1'b0;
        else        frame_sync <= boundary;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic ch_wr;
        // Out-of-range wr_ch matches no channel and is silently dropped.
        assign ch_wr = wr_en && (wr_ch == CHW'(c));

        servo_pwm_channel #(
            .POS_W       (POS_W),
            .FRAME_TICKS (FRAME_TICKS),
            .MIN_TICKS   (MIN_TICKS),
            .RESET_POS   (RESET_POS)
`ifdef SERVO_SLEW_EN
            ,
            .SLEW_STEP   (SLEW_STEP)
`endif
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (ch_wr),
            .wr_pos   (wr_pos),
            .en_req   (ch_en[c]),
            .boundary (boundary),
            .fc       (fc),
            .servo    (servo[c])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Scoreboard bench for servo_pwm_bank: the stimulus side predicts per-frame
// pulse widths from a position/enable model; the monitor measures each frame.
module tb_servo_pwm_bank;

    localparam int NCH         = 3;
    localparam int POS_W       = 4;
    localparam int DIV         = 4;
    localparam int FRAME_TICKS = 64;
    localparam int MIN_TICKS   = 8;
    localparam int RESET_POS   = 0;
    localparam int SLEW_STEP   = 2;
    localparam int FRAME_CLKS  = DIV * FRAME_TICKS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic [POS_W-1:0] wr_pos = '0;
    logic [NCH-1:0]   ch_en = '0;
    logic [NCH-1:0]   servo;
    logic             frame_sync;

    servo_pwm_bank #(
        .NCH(NCH), .POS_W(POS_W), .DIV(DIV), .FRAME_TICKS(FRAME_TICKS),
        .MIN_TICKS(MIN_TICKS), .RESET_POS(RESET_POS), .SLEW_STEP(SLEW_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .servo(servo), .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    typedef struct { int hi [NCH]; } frame_exp_t;

    frame_exp_t exp_q[$];
    int m_pending [NCH];
    int m_active  [NCH];
    bit m_en      [NCH];
    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int frames_seen = 0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference position update at a frame boundary.
    function automatic int next_of(input int p, input int a);
`ifdef SERVO_SLEW_EN
        if (p > a) return (p - a > SLEW_STEP) ? a + SLEW_STEP : p;
        if (a > p) return (a - p > SLEW_STEP) ? a - SLEW_STEP : p;
        return p;
`else
        return p;
`endif
    endfunction

    // Posedges since reset release; the boundary is every FRAME_CLKS-th edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic model_reset();
        frame_exp_t e;
        for (int c = 0; c < NCH; c++) begin
            m_pending[c] = RESET_POS;
            m_active[c]  = RESET_POS;
            m_en[c]      = 1'b0;
            e.hi[c]      = 0;
        end
        exp_q.push_back(e);
    endtask

    // Drive one clock of stimulus (called at a negedge) and advance the model.
    task automatic cycle(input bit we, input int ch, input int pos, input logic [NCH-1:0] en);
        frame_exp_t e;
        wr_en  = we;
        wr_ch  = 2'(ch);
        wr_pos = POS_W'(pos);
        ch_en  = en;
        if ((edge_n + 1) % FRAME_CLKS == 0) begin
            for (int c = 0; c < NCH; c++) begin
                m_active[c] = next_of(m_pending[c], m_active[c]);
                m_en[c]     = en[c];
                e.hi[c]     = m_en[c] ? (MIN_TICKS + m_active[c]) * DIV : 0;
            end
            exp_q.push_back(e);
        end
        if (we && ch < NCH) m_pending[ch] = pos;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] en);
        repeat (n) cycle(1'b0, 0, 0, en);
    endtask

    // Idle until the next call to cycle() lands on the boundary edge.
    task automatic to_boundary(input logic [NCH-1:0] en);
        while ((edge_n + 1) % FRAME_CLKS != 0) cycle(1'b0, 0, 0, en);
    endtask

    task automatic release_reset();
        model_reset();
        rst_n  = 1'b1;
        mon_on = 1'b1;
    endtask

    // Monitor: accumulate per-frame high time and first-rise offset; judge at frame_sync.
    int hi_cnt   [NCH];
    int first_hi [NCH];
    int off;
    int last_sync;
    always @(negedge clk) begin
        frame_exp_t e;
        if (!mon_on) begin
            for (int c = 0; c < NCH; c++) begin
                hi_cnt[c] = 0;
                first_hi[c] = -1;
            end
            off = 0;
            last_sync = 0;
        end else begin
            if (frame_sync) begin
                frames_seen++;
                check("sync_period", edge_n - last_sync, FRAME_CLKS);
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < NCH; c++) begin
                        check($sformatf("width_ch%0d", c), hi_cnt[c], e.hi[c]);
                        if (e.hi[c] > 0) check($sformatf("rise_ch%0d", c), first_hi[c], 1);
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    hi_cnt[c] = 0;
                    first_hi[c] = -1;
                end
                off = 0;
                last_sync = edge_n;
            end
            for (int c = 0; c < NCH; c++) begin
                if (servo[c]) begin
                    if (first_hi[c] < 0) first_hi[c] = off;
                    hi_cnt[c]++;
                end
            end
            off++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] en;
        repeat (3) @(negedge clk);
        check("reset_servo", int'(servo), 0);
        check("reset_sync", int'(frame_sync), 0);
        release_reset();

        // All channels disabled: no pulses, sync every FRAME_CLKS.
        idle(2 * FRAME_CLKS + 10, 3'b000);

        // ch0 pos 5 -> 52 clks.
        cycle(1'b1, 0, 5, 3'b001);
        to_boundary(3'b001);
        idle(FRAME_CLKS, 3'b001);

        // Extremes on ch0; ch1 written but disabled.
        cycle(1'b1, 0, 0, 3'b001);
        cycle(1'b1, 1, 9, 3'b001);
        to_boundary(3'b001);
        idle(FRAME_CLKS, 3'b001);
        cycle(1'b1, 0, 15, 3'b001);
        to_boundary(3'b001);
        idle(FRAME_CLKS, 3'b001);

        // Write on the boundary cycle itself.
        to_boundary(3'b001);
        cycle(1'b1, 0, 3, 3'b001);
        to_boundary(3'b001);
        idle(FRAME_CLKS, 3'b001);

        // Out-of-range channel write is dropped.
        cycle(1'b1, 3, 9, 3'b001);
        to_boundary(3'b001);
        idle(FRAME_CLKS, 3'b001);

        // Reset in the middle of a pulse.
        cycle(1'b1, 0, 15, 3'b001);
        to_boundary(3'b001);
        idle(21, 3'b001);
        check("pre_reset_servo0", int'(servo[0]), 1);
        #3;
        rst_n  = 1'b0;
        mon_on = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_servo", int'(servo), 0);
        check("async_reset_sync", int'(frame_sync), 0);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        idle(2 * FRAME_CLKS + 10, 3'b001);

        // Large step 0 -> 10 (slew-limited when SERVO_SLEW_EN is defined).
        cycle(1'b1, 0, 10, 3'b001);
        idle(7 * FRAME_CLKS, 3'b001);

        // Randomised frames: random enables (also changed mid-frame) and writes.
        en = 3'($urandom_range(0, 7));
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < FRAME_CLKS; i++) begin
                if ($urandom_range(0, 63) == 0) en = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 40) == 0)
                    cycle(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), en);
                else
                    cycle(1'b0, 0, 0, en);
            end
        end
        to_boundary(en);
        cycle(1'b1, 2, 7, en);
        idle(FRAME_CLKS + 10, en);

        check("frames_checked", int'(frames_seen >= 25), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
